// File: rtl/ps2_pkg.sv
// Shared constants and FSM state encoding for the PS/2 keyboard receiver.
package ps2_pkg;
  localparam logic [7:0]  SC_EXTENDED = 8'hE0;
  localparam logic [7:0]  SC_BREAK    = 8'hF0;
  localparam int unsigned FRAME_BITS  = 11;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// Key-event handshake: producer holds an event until the consumer pulses key_ack.
interface ps2_keyboard_rx_if;
  logic [7:0] key_code;
  logic       key_release;
  logic       key_extended;
  logic       key_valid;
  logic       key_ack;

  modport master (output key_code, key_release, key_extended, key_valid, input key_ack);
  modport slave  (input key_code, key_release, key_extended, key_valid, output key_ack);
endinterface

// File: rtl/ps2_line_filter.sv
// Synchronises ps2_clk/ps2_data, glitch-filters the clock and flags filtered falling edges
// together with the data level sampled in the same cycle.
module ps2_line_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data_bit
);
  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   filt;
  logic [CW-1:0]          cnt;
  logic                   clk_s;
  logic                   data_s;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      filt      <= 1'b1;
      cnt       <= '0;
      fall      <= 1'b0;
      data_bit  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      data_bit  <= data_s;
      fall      <= 1'b0;
      // Any sample equal to the current level restarts the run, so short glitches never count.
      if (clk_s == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        filt <= clk_s;
        cnt  <= '0;
        fall <= filt;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: frame deserialiser, E0/F0 prefix folding and a
// single-entry event register released by key_ack.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ps2_clk,
  input  logic                      ps2_data,
  ps2_keyboard_rx_if.master         key,
  output logic                      overrun,
  output logic                      err_parity,
  output logic                      err_frame
);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          fall;
  logic          data_bit;
  rx_state_t     state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          par, par_n;
  logic [TW-1:0] tmo, tmo_n;
  logic          frame_err_n, par_err_n, done_n, tmo_err_n;
  logic          byte_done, tmo_err;
  logic          ext_flag, rel_flag;
  logic [7:0]    code_q;
  logic          rel_q, ext_q, valid_q;
  logic          ev;

  ps2_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .fall    (fall),
    .data_bit(data_bit)
  );

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    par_n       = par;
    frame_err_n = 1'b0;
    par_err_n   = 1'b0;
    done_n      = 1'b0;
    tmo_err_n   = 1'b0;
    tmo_n       = (fall || state == IDLE) ? '0 : tmo + TW'(1);
    unique case (state)
      IDLE: if (fall) begin
        if (!data_bit) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end else begin
          frame_err_n = 1'b1;
        end
      end
      DATA: if (fall) begin
        shift_n   = {data_bit, shift[7:1]};
        bit_cnt_n = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) state_n = PARITY;
      end
      PARITY: if (fall) begin
        par_n   = data_bit;
        state_n = STOP;
      end
      STOP: if (fall) begin
        if (!data_bit)               frame_err_n = 1'b1;
        else if (!(^{shift, par}))   par_err_n   = 1'b1;
        else                         done_n      = 1'b1;
        state_n = IDLE;
      end
    endcase
    if (state != IDLE && !fall && tmo == TW'(TIMEOUT_CYCLES - 1)) begin
      state_n   = IDLE;
      tmo_n     = '0;
      tmo_err_n = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      par        <= 1'b0;
      tmo        <= '0;
      err_frame  <= 1'b0;
      err_parity <= 1'b0;
      byte_done  <= 1'b0;
      tmo_err    <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      par        <= par_n;
      tmo        <= tmo_n;
      err_frame  <= frame_err_n | tmo_err_n;
      err_parity <= par_err_n;
      byte_done  <= done_n;
      tmo_err    <= tmo_err_n;
    end
  end

  assign ev = byte_done && shift != SC_EXTENDED && shift != SC_BREAK;

  // A timeout abandons only the partial byte; prefixes already received stay pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_flag <= 1'b0;
      rel_flag <= 1'b0;
    end else if ((err_frame && !tmo_err) || err_parity) begin
      ext_flag <= 1'b0;
      rel_flag <= 1'b0;
    end else if (byte_done) begin
      if (shift == SC_EXTENDED)   ext_flag <= 1'b1;
      else if (shift == SC_BREAK) rel_flag <= 1'b1;
      else begin
        ext_flag <= 1'b0;
        rel_flag <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q  <= '0;
      rel_q   <= 1'b0;
      ext_q   <= 1'b0;
      valid_q <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (ev) begin
        if (!valid_q || key.key_ack) begin
          code_q  <= shift;
          rel_q   <= rel_flag;
          ext_q   <= ext_flag;
          valid_q <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (key.key_ack) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign key.key_code     = code_q;
  assign key.key_release  = rel_q;
  assign key.key_extended = ext_q;
  assign key.key_valid    = valid_q;
endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- Receive-only PS/2 keyboard front end. Feeds the computer's keyboard input path from the board ps2_clk/ps2_data pins.
- Synchronises and filters the keyboard clock, then deserialises 11-bit frames.
- Folds the scan-code prefixes E0 (extended) and F0 (break) into one key event.
- Holds each event in a single-entry register until the CPU acknowledges it.

Parameters:
- SYNC_STAGES, 2: synchroniser flops on ps2_clk and ps2_data.
- FILTER_LEN, 8: consecutive equal samples required before the filtered ps2_clk changes level.
- TIMEOUT_CYCLES, 50000: clk cycles without a filtered falling edge before a partial frame is abandoned (1 ms at 50 MHz).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous active-high reset.
- ps2_clk, input, 1: raw keyboard clock (the top level drives the pad high-Z).
- ps2_data, input, 1: raw keyboard data.
- key_code, output, 8: scan code of the held event.
- key_release, output, 1: event was preceded by F0.
- key_extended, output, 1: event was preceded by E0.
- key_valid, output, 1: held event present; stays high until acknowledged.
- key_ack, input, 1: consumer pulse that clears key_valid.
- overrun, output, 1: one-cycle pulse when an event is dropped.
- err_parity, output, 1: one-cycle pulse on parity failure.
- err_frame, output, 1: one-cycle pulse on bad start bit, bad stop bit or timeout.

Behaviour:
- Reset (async, any state, including mid-frame):
  - all outputs 0, FSM to IDLE, bit counter 0, prefix flags cleared.
  - filter and synchroniser outputs set to 1 (the line-idle level).
- Filter:
  - filtered clock changes only after FILTER_LEN identical synchronised samples.
  - fall = filtered 1->0, registered; ps2_data is sampled in the same cycle.
- FSM:
  - IDLE: on fall with data=0 go to DATA and clear the counter. On fall with data=1 pulse err_frame and stay in IDLE.
  - DATA: on each fall shift data in LSB-first; after the 8th bit go to PARITY.
  - PARITY: on fall capture the bit, go to STOP.
  - STOP: on fall check two things. Stop bit must be 1, else err_frame. Parity must be odd (XOR of the 8 data bits and the parity bit = 1), else err_parity. If both fail, only err_frame pulses. Then return to IDLE. A good frame pulses byte_done the next cycle.
- Timeout:
  - the counter resets on every fall.
  - in any non-IDLE state, reaching TIMEOUT_CYCLES pulses err_frame and returns to IDLE.
  - the partial byte is discarded and the prefix flags are preserved.
- Decoder, on byte_done:
  - E0 sets ext_flag.
  - F0 sets rel_flag.
  - any other byte forms an event {byte, rel_flag, ext_flag} and then clears both flags.
  - any error pulse clears both flags.
- Publishing:
  - key_valid rises 1 cycle after byte_done, so 2 cycles after the stop-bit fall.
  - key_code, key_release and key_extended are stable while key_valid=1.
- Holding register:
  - key_ack with key_valid=1 clears key_valid next cycle; key_ack with key_valid=0 is ignored.
  - a new event while key_valid=1 and no key_ack is dropped; the old event is kept and overrun pulses.
  - a new event in the same cycle as key_ack loads the new event, keeps key_valid=1 and does not pulse overrun.
- Frames whose bits arrive in back-to-back fall cycles need no special handling; throughput is one byte per 11 falls.

Decomposition:
- Package ps2_pkg holds:
  - SC_EXTENDED = 8'hE0 and SC_BREAK = 8'hF0.
  - state encoding IDLE/DATA/PARITY/STOP.
  - FRAME_BITS = 11.
- Sub-module ps2_line_filter: synchroniser, glitch filter, falling-edge detect, data sample. Instanced once, with data passed through matching sync stages.

Test Plan:
- Frame for 0x1C (start 0, data bits 0,0,1,1,1,0,0,0, parity 0, stop 1), bit period 40 clk: key_valid rises 2 cycles after the last fall; key_code=0x1C, release=0, extended=0. Hold with no ack: key_valid stays 1. key_ack pulse: key_valid=0 next cycle.
- Bytes F0 then 1C: exactly one event, 0x1C with release=1. E0,F0,75: one event, 0x75 with release=1 and extended=1. Then 1C alone: flags back to 0.
- Parity flip on 0x1C (parity bit 1): err_parity pulses once, no event. Stop bit 0: err_frame pulses. A following E0,75 still yields extended=1 with no stale F0.
- Stop the clock after 4 data bits for TIMEOUT_CYCLES (set to 200): err_frame pulses, FSM back in IDLE. Next full 0x1C frame is decoded correctly.
- Overrun:
  - event 0x1C unacked, then 0x32: overrun pulses, key_code stays 0x1C.
  - repeat with key_ack asserted in the load cycle: key_code becomes 0x32, no overrun.
- Glitches and reset:
  - glitch pulses on ps2_clk shorter than FILTER_LEN (3 cycles low): no bit consumed.
  - rst asserted mid-frame: outputs 0 immediately with no clock edge needed; the next frame is decoded cleanly.
